// File: rtl/wrr_pkt_arbiter_if.sv
// wrr_pkt_arbiter_if: request/grant handshake between requesters and the packet arbiter
interface wrr_pkt_arbiter_if #(
  parameter int ARB_NUM = 8
);
  localparam int IW = $clog2(ARB_NUM);
  logic [ARB_NUM-1:0] req;
  logic [ARB_NUM-1:0] req_eop;
  logic               ready;
  logic [ARB_NUM-1:0] gnt;
  logic               gnt_vld;
  logic [IW-1:0]      gnt_idx;
  modport master (output req, req_eop, ready, input gnt, gnt_vld, gnt_idx);
  modport slave (input req, req_eop, ready, output gnt, gnt_vld, gnt_idx);
endinterface

// File: rtl/wrr_pkt_arbiter.sv
// wrr_pkt_arbiter: packet-locked weighted round-robin arbiter, one credit charged per packet
module wrr_pkt_arbiter #(
  parameter int ARB_NUM  = 8,
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  wrr_pkt_arbiter_if.slave    bus,
  input  logic [WEIGHT_W-1:0] weight_i [ARB_NUM],
  input  logic                weight_load_i,
  output logic                refill_o
);
  localparam int IW = $clog2(ARB_NUM);
  typedef enum logic [1:0] {IDLE, LOCK, REFILL} state_e;
  state_e              state_q, state_d;
  logic [ARB_NUM-1:0]  gnt_q, gnt_d, elig;
  logic [IW-1:0]       idx_q, idx_d, ptr_q, ptr_d, win;
  logic                found, acc;
  logic [WEIGHT_W-1:0] init_q [ARB_NUM];
  logic [WEIGHT_W-1:0] init_d [ARB_NUM];
  logic [WEIGHT_W-1:0] cred_q [ARB_NUM];
  logic [WEIGHT_W-1:0] cred_d [ARB_NUM];
  always_comb begin
    for (int i = 0; i < ARB_NUM; i++) elig[i] = bus.req[i] & (cred_q[i] != '0);
  end
  // first eligible requester at or after the pointer, wrapping
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 0; k < ARB_NUM; k++) begin
      if (!found && elig[(int'(ptr_q) + k) % ARB_NUM]) begin
        found = 1'b1;
        win = IW'((int'(ptr_q) + k) % ARB_NUM);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    init_d = init_q;
    cred_d = cred_q;
    acc = bus.req[idx_q] & bus.ready & bus.req_eop[idx_q];
    if (state_q == IDLE) begin
      if (found) begin
        gnt_d = {{(ARB_NUM-1){1'b0}}, 1'b1} << win;
        idx_d = win;
        state_d = LOCK;
      end else if (|bus.req) begin
        state_d = REFILL;
      end
    end else if (state_q == LOCK) begin
      if (acc) begin
        cred_d[idx_q] = (cred_q[idx_q] == '0) ? '0 : cred_q[idx_q] - 1'b1;
        ptr_d = (idx_q == IW'(ARB_NUM-1)) ? '0 : idx_q + 1'b1;
        gnt_d = '0;
        idx_d = '0;
        state_d = IDLE;
      end
    end else begin
      cred_d = init_q;
      state_d = IDLE;
    end
    if (weight_load_i) begin
      init_d = weight_i;
      cred_d = weight_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      for (int i = 0; i < ARB_NUM; i++) begin
        init_q[i] <= WEIGHT_W'(1);
        cred_q[i] <= WEIGHT_W'(1);
      end
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      init_q <= init_d;
      cred_q <= cred_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.gnt_vld = |gnt_q;
  assign bus.gnt_idx = idx_q;
  assign refill_o = (state_q == REFILL);
endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// tb_wrr_pkt_arbiter: directed scenarios plus random packet traffic against a credit/owner reference model
module tb_wrr_pkt_arbiter;
  localparam int N = 4, W = 4;
  logic clk = 1'b0, rst, wl, refill;
  logic [W-1:0] weight [N];
  int n_vec = 0, n_err = 0;
  int m_owner, m_ptr, m_beat, m_cred [N], m_init [N];
  bit m_refill;
  int rem [N], cnt [N];
  wrr_pkt_arbiter_if #(.ARB_NUM(N)) bus ();
  wrr_pkt_arbiter #(.ARB_NUM(N), .WEIGHT_W(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .weight_i(weight), .weight_load_i(wl), .refill_o(refill)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // model: owner = granted requester or -1, credits as plain integers
  task automatic model_step();
    int win;
    m_beat = -1;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_refill = 0;
      for (int i = 0; i < N; i++) begin m_cred[i] = 1; m_init[i] = 1; end
      return;
    end
    if (m_refill) begin
      for (int i = 0; i < N; i++) m_cred[i] = m_init[i];
      m_refill = 0;
    end else if (m_owner >= 0) begin
      if (bus.req[m_owner] && bus.ready) begin
        m_beat = m_owner;
        if (bus.req_eop[m_owner]) begin
          if (m_cred[m_owner] > 0) m_cred[m_owner]--;
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end else begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (win < 0 && bus.req[j] && m_cred[j] > 0) win = j;
      end
      if (win >= 0) m_owner = win;
      else if (bus.req != 0) m_refill = 1;
    end
    if (wl) for (int i = 0; i < N; i++) begin m_init[i] = weight[i]; m_cred[i] = weight[i]; end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("gnt", 32'(bus.gnt), 32'(m_owner >= 0 ? (1 << m_owner) : 0));
    chk("vld", 32'(bus.gnt_vld), 32'(m_owner >= 0));
    chk("idx", 32'(bus.gnt_idx), 32'(m_owner >= 0 ? m_owner : 0));
    chk("refill", 32'(refill), 32'(m_refill));
  endtask
  task automatic do_reset();
    rst = 1; wl = 0; bus.req = '0; bus.req_eop = '0; bus.ready = 1;
    tick();
    rst = 0;
  endtask
  initial begin
    int exp_g [11] = '{1, 0, 2, 0, 4, 0, 8, 0, 0, 0, 1};
    int exp_r [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int rd [7] = '{1, 0, 1, 0, 1, 0, 1};
    int b, rounds, first;
    bit prev;
    for (int i = 0; i < N; i++) weight[i] = '0;
    do_reset();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_refill", 32'(refill), 0);
    // plain round robin then refill
    bus.req = 4'b1111; bus.req_eop = 4'b1111;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("t1_gnt", 32'(bus.gnt), 32'(exp_g[i]));
      chk("t1_refill", 32'(refill), 32'(exp_r[i]));
    end
    // weights {3,1,0,2}: per-round packet counts
    do_reset();
    weight[0] = 3; weight[1] = 1; weight[2] = 0; weight[3] = 2; wl = 1;
    tick();
    wl = 0; bus.req = 4'b1111; bus.req_eop = 4'b1111;
    rounds = 0; prev = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.gnt_vld && !prev) cnt[bus.gnt_idx]++;
      prev = bus.gnt_vld;
      if (refill) begin
        chk("t2_cnt0", 32'(cnt[0]), 3);
        chk("t2_cnt1", 32'(cnt[1]), 1);
        chk("t2_cnt2", 32'(cnt[2]), 0);
        chk("t2_cnt3", 32'(cnt[3]), 2);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        rounds++;
      end
    end
    chk("t2_rounds", 32'(rounds >= 3), 1);
    // 4-beat packet with stalls: grant held, one credit charged
    do_reset();
    for (int i = 0; i < N; i++) weight[i] = 2;
    wl = 1;
    tick();
    wl = 0; bus.req = 4'b0010; bus.req_eop = 4'b0000;
    tick();
    chk("t3_lock", 32'(bus.gnt), 2);
    b = 0;
    for (int i = 0; i < 7; i++) begin
      bus.ready = rd[i][0];
      bus.req_eop[1] = (b == 3);
      tick();
      chk("t3_gnt", 32'(bus.gnt), (rd[i] != 0 && b == 3) ? 0 : 2);
      if (rd[i] != 0) b++;
    end
    bus.req_eop[1] = 1; bus.ready = 1;
    tick();
    chk("t3_regrant", 32'(bus.gnt), 2);
    tick();
    tick();
    chk("t3_refill", 32'(refill), 1);
    // weight load in the eop cycle wins over the decrement
    do_reset();
    bus.req = 4'b0001; bus.req_eop = 4'b0001; bus.ready = 0;
    tick();
    bus.ready = 1; weight[0] = 5; weight[1] = 1; weight[2] = 1; weight[3] = 1; wl = 1;
    tick();
    chk("t4_release", 32'(bus.gnt), 0);
    wl = 0; cnt[0] = 0; first = -1; prev = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (bus.gnt_vld && !prev) cnt[0]++;
      prev = bus.gnt_vld;
      if (refill && first < 0) first = cnt[0];
    end
    chk("t4_pkts", 32'(first), 5);
    // lone requester out of credit: refill then grant two cycles later
    do_reset();
    bus.req = 4'b0100; bus.req_eop = 4'b0100;
    tick();
    tick();
    tick();
    chk("t5_refill", 32'(refill), 1);
    chk("t5_gnt0", 32'(bus.gnt), 0);
    tick();
    chk("t5_gnt1", 32'(bus.gnt), 0);
    tick();
    chk("t5_gnt2", 32'(bus.gnt), 4);
    // reset during lock
    do_reset();
    bus.req = 4'b0100; bus.req_eop = 4'b0000;
    tick();
    tick();
    rst = 1;
    tick();
    chk("t6_rst_gnt", 32'(bus.gnt), 0);
    rst = 0; bus.req = 4'b1010; bus.req_eop = 4'b1010;
    tick();
    chk("t6_first", 32'(bus.gnt), 2);
    // random packet traffic
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      wl = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        if (wl) weight[i] = W'($urandom_range(0, 3));
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 4);
        bus.req[i] = (rem[i] != 0) && !(m_owner == i && $urandom_range(0, 7) == 0);
        bus.req_eop[i] = (rem[i] == 1);
      end
      bus.ready = ($urandom_range(0, 3) != 0);
      tick();
      if (m_beat >= 0) rem[m_beat]--;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
